// File: rtl/touch_int_irq.sv
// Touch-controller INT conditioner: synchronizes and debounces the INT line, captures
// edges, counts events and raises a level IRQ, all behind a 4-register Avalon-MM slave.
module touch_int_irq #(
    parameter int DEBOUNCE_RST = 500,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        int_in,
    output logic        irq
);
    localparam logic [1:0]       A_STATUS  = 2'd0;
    localparam logic [1:0]       A_CONTROL = 2'd1;
    localparam logic [1:0]       A_EVCOUNT = 2'd2;
    localparam logic [1:0]       A_THRESH  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] THR_RST   = CNT_W'(DEBOUNCE_RST);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d, deb_flip;
    logic [CNT_W-1:0] cnt_q, cnt_d, thr_eff;
    logic             fall_q, fall_d, rise_q, rise_d;
    logic             fall_en_q, fall_en_d, rise_en_q, rise_en_d;
    logic [CNT_W-1:0] evcnt_q, evcnt_d;
    logic [CNT_W-1:0] thresh_q, thresh_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata[31:CNT_W];

    always_comb begin
        thr_eff = (thresh_q == '0) ? CNT_ONE : thresh_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        if (sync2_q != deb_q) begin
            // widened compare so an all-ones count cannot wrap past the threshold
            if (({1'b0, cnt_q} + {1'b0, CNT_ONE}) >= {1'b0, thr_eff}) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    assign deb_flip = deb_d ^ deb_q;

    always_comb begin
        fall_d    = fall_q;
        rise_d    = rise_q;
        fall_en_d = fall_en_q;
        rise_en_d = rise_en_q;
        evcnt_d   = evcnt_q;
        thresh_d  = thresh_q;
        if (wr_en) begin
            case (address)
                A_STATUS: begin
                    if (writedata[1]) fall_d = 1'b0;
                    if (writedata[2]) rise_d = 1'b0;
                end
                A_CONTROL: begin
                    fall_en_d = writedata[0];
                    rise_en_d = writedata[1];
                end
                A_EVCOUNT: evcnt_d  = '0;
                A_THRESH:  thresh_d = writedata[CNT_W-1:0];
            endcase
        end
        // a capture or count on this edge overrides a same-edge software clear
        if (deb_flip) begin
            if (deb_d) rise_d = 1'b1;
            else       fall_d = 1'b1;
            if (wr_en && (address == A_EVCOUNT)) evcnt_d = CNT_ONE;
            else if (evcnt_q != '1)              evcnt_d = evcnt_q + CNT_ONE;
        end

        rdata_d = '0;
        case (address)
            A_STATUS:  rdata_d[2:0]       = {rise_q, fall_q, deb_q};
            A_CONTROL: rdata_d[1:0]       = {rise_en_q, fall_en_q};
            A_EVCOUNT: rdata_d[CNT_W-1:0] = evcnt_q;
            A_THRESH:  rdata_d[CNT_W-1:0] = thresh_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            deb_q     <= 1'b1;
            cnt_q     <= '0;
            fall_q    <= 1'b0;
            rise_q    <= 1'b0;
            fall_en_q <= 1'b0;
            rise_en_q <= 1'b0;
            evcnt_q   <= '0;
            thresh_q  <= THR_RST;
            rdata_q   <= '0;
        end else begin
            sync1_q   <= int_in;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            fall_q    <= fall_d;
            rise_q    <= rise_d;
            fall_en_q <= fall_en_d;
            rise_en_q <= rise_en_d;
            evcnt_q   <= evcnt_d;
            thresh_q  <= thresh_d;
            rdata_q   <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = (fall_q & fall_en_q) | (rise_q & rise_en_q);

endmodule
